// File: rtl/serial_subtractor.sv
// Digit-serial two's-complement subtractor: a - b - bin, DIGIT bits per clock, LSB digit first.
// Result, borrow-out and signed overflow are registered and update only on the completing edge.
module serial_subtractor #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] diff_q;
    logic             brw_q;
    logic             borrow_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;
    logic [CW-1:0]    cnt_q;

    logic [31:0]      base;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT-1:0] d_dig;
    logic             d_bo;
    logic [WIDTH-1:0] res_d;
    logic             ovf_d;

    // One digit of the subtraction plus the partial result it completes.
    always_comb begin
        base  = 32'(cnt_q) * DIGIT;
        a_dig = a_q[base +: DIGIT];
        b_dig = b_q[base +: DIGIT];
        {d_bo, d_dig} = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, brw_q};
        res_d = res_q;
        res_d[base +: DIGIT] = d_dig;
        ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            brw_q    <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        brw_q   <= bin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    // start is ignored here; latched operands stay untouched.
                    res_q <= res_d;
                    brw_q <= d_bo;
                    if (cnt_q == LAST) begin
                        diff_q   <= res_d;
                        borrow_q <= d_bo;
                        ovf_q    <= ovf_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = ovf_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: four instances (DIGIT 32/8/4/1) sharing operands, each with its own start.
module tb_serial_subtractor;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       start_v;
    logic [31:0]      a;
    logic [31:0]      b;
    logic             bin;
    logic [3:0][31:0] diff_v;
    logic [3:0]       borrow_v;
    logic [3:0]       ovf_v;
    logic [3:0]       busy_v;
    logic [3:0]       done_v;

    int errors = 0;
    int checks = 0;
    int unsigned ndig [4] = '{1, 4, 8, 32};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned DG = (g == 0) ? 32 : (g == 1) ? 8 : (g == 2) ? 4 : 1;
        serial_subtractor #(.WIDTH(32), .DIGIT(DG)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start_v[g]),
            .a        (a),
            .b        (b),
            .bin      (bin),
            .diff     (diff_v[g]),
            .borrow   (borrow_v[g]),
            .overflow (ovf_v[g]),
            .busy     (busy_v[g]),
            .done     (done_v[g])
        );
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] diff;
        logic        borrow;
        logic        ovf;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: full-width arithmetic on the operands as sampled at acceptance.
    task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic mbin,
                         output logic [31:0] md, output logic mbo, output logic mov);
        logic [32:0] wide;
        wide = {1'b0, ma} - {1'b0, mb} - 33'(mbin);
        md   = wide[31:0];
        mbo  = (33'(ma) < 33'(mb) + 33'(mbin));
        mov  = (ma[31] != mb[31]) && (md[31] != ma[31]);
    endtask

    // Pulse start on instance k, optionally scramble inputs in flight, wait for done.
    task automatic run_op(input int k, input logic [31:0] oa, input logic [31:0] ob, input logic obin,
                          input bit scramble, output int lat, output int busy_cnt);
        lat = -1;
        busy_cnt = 0;
        @(negedge clk);
        a = oa; b = ob; bin = obin; start_v[k] = 1'b1;
        @(posedge clk); #1;
        start_v[k] = 1'b0;
        if (busy_v[k]) busy_cnt++;
        for (int n = 1; n <= 64; n++) begin
            if (scramble) begin
                a = $urandom; b = $urandom; bin = 1'($urandom);
            end
            @(posedge clk); #1;
            if (busy_v[k]) busy_cnt++;
            if (done_v[k]) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) begin
            errors++;
            $display("FAIL timeout: instance %0d never raised done", k);
        end
    endtask

    initial begin
        int lat;
        int bc;
        int dcount;
        logic [31:0] ed;
        logic eb;
        logic eo;

        vecs[0] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[1] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
        vecs[2] = '{32'd5,         32'd10,        1'b0, 32'hFFFF_FFFB, 1'b1, 1'b0};
        vecs[3] = '{32'd999,       32'd999,       1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[4] = '{32'h0,         32'h0,         1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[5] = '{32'h0,         32'h0,         1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
        vecs[8] = '{32'd2000,      32'd500,       1'b0, 32'h0000_05DC, 1'b0, 1'b0};
        vecs[9] = '{32'h1234_5678, 32'h0000_0678, 1'b0, 32'h1234_5000, 1'b0, 1'b0};

        rst = 1'b1; start_v = '0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("reset_outputs", {27'd0, busy_v[k], done_v[k], borrow_v[k], ovf_v[k], diff_v[k] != 0}, 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Table vectors on the DIGIT=4 instance, with latency and busy length.
        for (int i = 0; i < 10; i++) begin
            run_op(2, vecs[i].a, vecs[i].b, vecs[i].bin, 1'b0, lat, bc);
            chk("vec_diff",   64'(diff_v[2]),   64'(vecs[i].diff));
            chk("vec_borrow", 64'(borrow_v[2]), 64'(vecs[i].borrow));
            chk("vec_ovf",    64'(ovf_v[2]),    64'(vecs[i].ovf));
            chk("vec_latency", 64'(lat), 64'd8);
            chk("vec_busy_cycles", 64'(bc), 64'd8);
        end

        // Back-to-back: restart in the DONE cycle.
        run_op(2, 32'd5, 32'd10, 1'b0, 1'b0, lat, bc);
        chk("b2b_first_diff", 64'(diff_v[2]), 64'hFFFF_FFFB);
        a = 32'd999; b = 32'd999; bin = 1'b1; start_v[2] = 1'b1;
        @(posedge clk); #1;
        start_v[2] = 1'b0;
        chk("b2b_done_single", 64'(done_v[2]), 64'd0);
        chk("b2b_busy_again", 64'(busy_v[2]), 64'd1);
        chk("b2b_hold_diff", 64'(diff_v[2]), 64'hFFFF_FFFB);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (done_v[2]) begin
                lat = n;
                break;
            end
        end
        chk("b2b_latency", 64'(lat), 64'd8);
        chk("b2b_diff",   64'(diff_v[2]),   64'hFFFF_FFFF);
        chk("b2b_borrow", 64'(borrow_v[2]), 64'd1);
        chk("b2b_ovf",    64'(ovf_v[2]),    64'd0);

        // Start re-pulsed mid-run and operands changing every cycle.
        @(negedge clk);
        a = 32'h0000_000A; b = 32'h0000_0014; bin = 1'b0; start_v[2] = 1'b1;
        @(posedge clk); #1;
        start_v[2] = 1'b0;
        dcount = 0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            a = $urandom; b = $urandom;
            start_v[2] = (n == 3);
            if (n == 3) begin
                a = 32'h0; b = 32'h0;
            end
            @(posedge clk); #1;
            start_v[2] = 1'b0;
            if (done_v[2]) begin
                dcount++;
                if (lat < 0) lat = n;
            end
            if (n == 8) begin
                chk("ignore_diff",   64'(diff_v[2]),   64'hFFFF_FFF6);
                chk("ignore_borrow", 64'(borrow_v[2]), 64'd1);
                chk("ignore_ovf",    64'(ovf_v[2]),    64'd0);
            end
        end
        chk("ignore_done_count", 64'(dcount), 64'd1);
        chk("ignore_latency", 64'(lat), 64'd2 * 4);
        chk("ignore_hold_diff", 64'(diff_v[2]), 64'hFFFF_FFF6);

        // Reset mid-operation wipes outputs and suppresses done.
        @(negedge clk);
        a = 32'd2000; b = 32'd500; bin = 1'b0; start_v[2] = 1'b1;
        @(posedge clk); #1;
        start_v[2] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_outputs", {27'd0, busy_v[2], done_v[2], borrow_v[2], ovf_v[2], diff_v[2] != 0}, 64'd0);
        dcount = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (done_v[2] || diff_v[2] != 0) dcount++;
        end
        chk("rst_mid_no_done", 64'(dcount), 64'd0);
        run_op(2, 32'd2000, 32'd500, 1'b0, 1'b0, lat, bc);
        chk("rst_after_diff", 64'(diff_v[2]), 64'h0000_05DC);
        chk("rst_after_latency", 64'(lat), 64'd8);

        // Randomised operations over all DIGIT sizes with in-flight input scrambling.
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rbin;
            int          k;
            k    = i % 4;
            ra   = $urandom;
            rb   = (i % 16 == 5) ? ra : $urandom;
            rbin = 1'($urandom);
            model(ra, rb, rbin, ed, eb, eo);
            run_op(k, ra, rb, rbin, (i % 2) == 1, lat, bc);
            chk("rand_result", {30'd0, borrow_v[k], ovf_v[k], diff_v[k]}, {30'd0, eb, eo, ed});
            chk("rand_latency", 64'(lat), 64'(ndig[k]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 4, bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  request to begin a subtraction; sampled only when busy=0.
REQ-006 SHALL have port a  input  WIDTH  minuend, two's complement.
REQ-007 SHALL have port b  input  WIDTH  subtrahend, two's complement.
REQ-008 SHALL have port bin  input  1  borrow-in.
REQ-009 SHALL have port diff  output  WIDTH  registered result a - b - bin, mod 2^WIDTH.
REQ-010 SHALL have port borrow  output  1  registered unsigned borrow-out: 1 iff unsigned a < unsigned b + bin.
REQ-011 SHALL have port overflow  output  1  registered signed overflow of the subtraction.
REQ-012 SHALL have port busy  output  1  high while digits are being processed.
REQ-013 SHALL have port done  output  1  one-cycle pulse marking valid diff/borrow/overflow.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE or DONE with start=1 at an edge (acceptance edge E0) SHALL latch a, b, bin, clear the digit counter, enter RUN, set busy=1.
REQ-016 IDLE or DONE with start=0 SHALL go to IDLE; done SHALL deassert on leaving DONE.
REQ-017 In RUN, each edge Ei (i=1..WIDTH/DIGIT) SHALL compute digit i-1 (LSB digit first) as a_digit - b_digit - running borrow, seeded with latched bin at E1.
REQ-018 The running borrow SHALL propagate digit to digit; the borrow out of the top digit SHALL become output borrow.
REQ-019 overflow SHALL be 1 iff a[WIDTH-1] != b[WIDTH-1] and diff[WIDTH-1] != a[WIDTH-1], using latched operands.
REQ-020 At edge E(WIDTH/DIGIT) (E8 at defaults) the FSM SHALL update diff, borrow and overflow together, enter DONE, set busy=0, done=1.
REQ-021 diff, borrow, overflow SHALL change only at the completing edge, at reset, and nowhere else; they SHALL hold between operations.
REQ-022 start while busy=1 SHALL be ignored; the in-flight operation and latched operands SHALL be unaffected.
REQ-023 Changes on a, b, bin after E0 SHALL NOT affect the in-flight result.
REQ-024 start=1 in the DONE cycle SHALL be accepted as a new E0 (back-to-back, no idle gap); done SHALL still be high only for that single DONE cycle.
REQ-025 Latency: exactly WIDTH/DIGIT edges from acceptance to done; throughput one result per WIDTH/DIGIT+1 cycles.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, busy=0, done=0, diff=0, borrow=0, overflow=0, clear latched operands and counter.
REQ-027 rst SHALL take priority over start and over any RUN progress, including mid-operation; no partial result SHALL ever appear on diff.
REQ-028 The first edge with rst=0 SHALL be able to accept start.

Verification
REQ-029 a=0x80000000, b=0x00000001, bin=0, start one cycle -> done after 8 edges; diff=0x7FFFFFFF, overflow=1, borrow=0; busy high for exactly 8 cycles.
REQ-030 a=0x7FFFFFFF, b=0xFFFFFFFF, bin=0 -> diff=0x80000000, overflow=1, borrow=1.
REQ-031 a=5, b=10, bin=0 -> diff=0xFFFFFFFB, overflow=0, borrow=1; then a=999, b=999, bin=1 back-to-back via start in DONE cycle -> diff=0xFFFFFFFF, overflow=0, borrow=1, second done exactly 8 edges after second E0.
REQ-032 a=0x0000000A, b=0x00000014, start; re-pulse start with a=0, b=0 at E3; change a, b every cycle -> diff=0xFFFFFFF6, borrow=1, overflow=0; only one done pulse.
REQ-033 Start a=2000, b=500; assert rst at E4 -> next cycle busy=0, done=0, diff=0, borrow=0, overflow=0, no done pulse; new start a=2000, b=500 -> diff=0x000005DC after 8 edges.
REQ-034 Random a, b, bin (>=1000 ops, WIDTH=32 with DIGIT in {1,4,8,32}) -> diff, borrow, overflow match a reference model of a - b - bin at every done pulse.
